bht_init_seq: RTL and testbench
===============================

Name: bht_init_seq

Overview:
- Sequencer that owns the BHT's synchronous init port (bht_rst/bht_addr/bht_init) and walks every entry to a known 2-bit state.
- Runs a full sweep after power-on reset and on each software/CSR flush request (e.g. context switch).
- Stalls the fetch/branch pipeline while sweeping; for flushes it first waits for the pipeline to drain, so MEM-stage BHT updates cannot collide with init writes.
- Sits between the core control unit and the BHT instance.

Parameters:
BHT_SIZE, 256, number of BHT entries swept (power of two, >= 2)
ADDR_W, 8, width of bht_addr (log2 BHT_SIZE)
INIT_STATE, 2'b01, counter value written by the power-on sweep (weakly not-taken)

Ports:
clk  in  1  clock; all state on rising edge
rst_i  in  1  reset, asynchronous, active-high
flush_req  in  1  level/pulse request to re-initialise the whole BHT
flush_val  in  2  counter value for a flush sweep; sampled when the request is accepted
pipe_empty  in  1  high when no branch is in EX/MEM (no BHT update pending)
bht_rst  out  1  drives BHT rst_i; high = write bht_init to bht_addr this edge
bht_addr  out  ADDR_W  entry index being initialised
bht_init  out  2  value written to the indexed entry
stall  out  1  freeze fetch/branch pipeline
init_done  out  1  high when the BHT is valid and no sweep or drain is active
flush_ack  out  1  one-cycle pulse when a flush sweep completes
busy_cnt  out  ADDR_W+1  entries remaining in current sweep (debug)

Behaviour:
- States: SWEEP, DONE, DRAIN. All outputs are registered.
- Reset (rst_i=1, async):
  - state=SWEEP, bht_rst=1, bht_addr=0, bht_init=INIT_STATE, stall=1, init_done=0, flush_ack=0, busy_cnt=BHT_SIZE, pending=0.
  - Outputs hold while rst_i is high.
- SWEEP:
  - bht_rst=1, stall=1.
  - Each edge: bht_addr+=1, busy_cnt-=1. Edge n after entry writes index n-1.
  - On the edge that writes index BHT_SIZE-1: bht_addr wraps to 0, busy_cnt=0, bht_rst=0, state=DONE.
  - bht_rst is therefore high for exactly BHT_SIZE cycles after reset release or after DRAIN exit.
- DONE:
  - bht_rst=0, stall=0, init_done=1.
  - If flush_req=1 or pending=1: capture flush_val (or the value latched with pending) into bht_init, clear pending, go to DRAIN; stall=1 and init_done=0 from the next cycle.
- DRAIN:
  - stall=1, bht_rst=0.
  - When pipe_empty=1: state=SWEEP, bht_addr=0, busy_cnt=BHT_SIZE. The first init write occurs on the following edge.
  - No timeout.
- flush_ack:
  - Asserted for 1 cycle, in the first DONE cycle after a flush-initiated sweep.
  - Never asserted after a power-on sweep.
- flush_req while in SWEEP or DRAIN:
  - Sets pending and latches flush_val.
  - Further requests before service merge into one; the latest flush_val wins.
  - The sweep in progress is not restarted.
- flush_req on the same edge the sweep finishes: treated as pending. DONE lasts 1 cycle (init_done=1, flush_ack as applicable), then DRAIN.
- rst_i mid-sweep or mid-drain: immediate return to reset values. Pending and flush_val are discarded; the power-on sweep restarts from 0.
- pipe_empty is ignored outside DRAIN.

Test Plan:
- Power-on: assert rst_i 3 cycles, release -> bht_rst=1 for exactly 256 cycles with bht_addr 0..255, bht_init=01. Cycle 257: init_done=1, stall=0, flush_ack stays 0. All 256 BHT entries read 01.
- Flush with busy pipe: in DONE pulse flush_req with flush_val=11, hold pipe_empty=0 for 5 cycles -> stall=1, bht_rst=0 during those 5 cycles. Then 256-cycle sweep writing 11. Then flush_ack=1 for one cycle. All entries read 11.
- Merged requests: during a sweep pulse flush_req with val=00, then val=10 -> exactly one extra drain+sweep, writing 10, and exactly one flush_ack.
- Boundary: raise flush_req on the edge that writes entry 255 -> one DONE cycle, then DRAIN. Second sweep writes the new value; no entry is skipped.
- Async reset mid-sweep: assert rst_i asynchronously at bht_addr=100 -> outputs return to reset values immediately, without waiting for a clk edge. After release the sweep restarts at 0 with INIT_STATE, and pending is cleared.
- BHT integration: after power-on, train entry 5 to 11, then flush with 00 -> entry 5 reads 00, T_NT follows the new state, and no MEM-stage update lands during the sweep.

Source files
------------

// File: rtl/bht_init_seq_if.sv
// Interface bundling the control-unit request side and the BHT init port of bht_init_seq.
//
// Signals
//   flush_req  : request to re-initialise the whole BHT (level or pulse)
//   flush_val  : counter value for a flush sweep, sampled when the request is taken
//   pipe_empty : no branch in EX/MEM, so no BHT update is pending
//   bht_rst    : BHT init write enable (writes bht_init to bht_addr on this edge)
//   bht_addr   : entry index being initialised
//   bht_init   : value written to the indexed entry
//   stall      : freeze fetch/branch pipeline
//   init_done  : BHT valid, no sweep or drain active
//   flush_ack  : one-cycle pulse when a flush sweep completes
//   busy_cnt   : entries remaining in the current sweep (debug)
//
// Modports
//   master : the sequencer (drives the BHT init port and pipeline controls)
//   slave  : the surrounding core / BHT side
interface bht_init_seq_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              flush_req;
  logic [1:0]        flush_val;
  logic              pipe_empty;
  logic              bht_rst;
  logic [ADDR_W-1:0] bht_addr;
  logic [1:0]        bht_init;
  logic              stall;
  logic              init_done;
  logic              flush_ack;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    input  flush_req,
    input  flush_val,
    input  pipe_empty,
    output bht_rst,
    output bht_addr,
    output bht_init,
    output stall,
    output init_done,
    output flush_ack,
    output busy_cnt
  );

  modport slave (
    output flush_req,
    output flush_val,
    output pipe_empty,
    input  bht_rst,
    input  bht_addr,
    input  bht_init,
    input  stall,
    input  init_done,
    input  flush_ack,
    input  busy_cnt
  );
endinterface

// File: rtl/bht_init_seq.sv
// BHT initialisation sequencer.
//
// Owns the BHT's synchronous init port and walks every entry to a known 2-bit counter value.
// A full sweep runs after power-on reset (writing INIT_STATE) and after each flush request
// (writing the requested value). Flush sweeps first wait for the pipeline to drain so that
// MEM-stage BHT updates never collide with init writes. The fetch/branch pipeline is stalled
// for the whole drain and sweep. All outputs are registered.
//
// Ports
//   clk   : clock, all state on the rising edge
//   rst_i : asynchronous active-high reset
//   bus   : bht_init_seq_if.master (flush request, pipe_empty, BHT init port, stall,
//           init_done, flush_ack, busy_cnt)
module bht_init_seq #(
  parameter int unsigned BHT_SIZE   = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input logic            clk,
  input logic            rst_i,
  bht_init_seq_if.master bus
);

  localparam int unsigned       CntW     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BHT_SIZE - 1);
  localparam logic [CntW-1:0]   FullCnt  = CntW'(BHT_SIZE);

  typedef enum logic [1:0] {
    StSweep,
    StDone,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic              bht_rst_q, bht_rst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        init_q, init_d;
  logic              stall_q, stall_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // A request that arrived while busy, and the latest value that came with it.
  logic              pend_q, pend_d;
  logic [1:0]        pend_val_q, pend_val_d;
  // Set once a flush has been accepted; only reset returns to a power-on sweep, so this
  // stays set for every later sweep and gates flush_ack.
  logic              flush_sweep_q, flush_sweep_d;

  always_comb begin
    state_d       = state_q;
    bht_rst_d     = bht_rst_q;
    addr_d        = addr_q;
    init_d        = init_q;
    stall_d       = stall_q;
    done_d        = done_q;
    ack_d         = 1'b0;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    pend_val_d    = pend_val_q;
    flush_sweep_d = flush_sweep_q;

    unique case (state_q)
      StSweep: begin
        // Requests while sweeping are deferred; the running sweep is never restarted.
        if (bus.flush_req) begin
          pend_d     = 1'b1;
          pend_val_d = bus.flush_val;
        end
        bht_rst_d = 1'b1;
        stall_d   = 1'b1;
        addr_d    = addr_q + 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (addr_q == LastAddr) begin
          // This edge writes the last entry.
          state_d   = StDone;
          addr_d    = '0;
          cnt_d     = '0;
          bht_rst_d = 1'b0;
          stall_d   = 1'b0;
          done_d    = 1'b1;
          ack_d     = flush_sweep_q;
        end
      end

      StDone: begin
        if (bus.flush_req || pend_q) begin
          // A fresh request on this edge is newer than anything held in pending.
          init_d        = bus.flush_req ? bus.flush_val : pend_val_q;
          pend_d        = 1'b0;
          flush_sweep_d = 1'b1;
          state_d       = StDrain;
          stall_d       = 1'b1;
          done_d        = 1'b0;
        end
      end

      StDrain: begin
        if (bus.flush_req) begin
          pend_d     = 1'b1;
          pend_val_d = bus.flush_val;
        end
        if (bus.pipe_empty) begin
          // First init write happens on the following edge.
          state_d   = StSweep;
          addr_d    = '0;
          cnt_d     = FullCnt;
          bht_rst_d = 1'b1;
        end
      end

      default: begin
        state_d   = StSweep;
        addr_d    = '0;
        cnt_d     = FullCnt;
        bht_rst_d = 1'b1;
        stall_d   = 1'b1;
        done_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StSweep;
      bht_rst_q     <= 1'b1;
      addr_q        <= '0;
      init_q        <= INIT_STATE;
      stall_q       <= 1'b1;
      done_q        <= 1'b0;
      ack_q         <= 1'b0;
      cnt_q         <= FullCnt;
      pend_q        <= 1'b0;
      pend_val_q    <= 2'b00;
      flush_sweep_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bht_rst_q     <= bht_rst_d;
      addr_q        <= addr_d;
      init_q        <= init_d;
      stall_q       <= stall_d;
      done_q        <= done_d;
      ack_q         <= ack_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      pend_val_q    <= pend_val_d;
      flush_sweep_q <= flush_sweep_d;
    end
  end

  assign bus.bht_rst   = bht_rst_q;
  assign bus.bht_addr  = addr_q;
  assign bus.bht_init  = init_q;
  assign bus.stall     = stall_q;
  assign bus.init_done = done_q;
  assign bus.flush_ack = ack_q;
  assign bus.busy_cnt  = cnt_q;

`ifndef SYNTHESIS
  // Init writes only ever happen with the pipeline frozen.
  a_rst_implies_stall: assert property (@(posedge clk) disable iff (rst_i)
      bus.bht_rst |-> bus.stall);
  a_done_not_stall: assert property (@(posedge clk) disable iff (rst_i)
      bus.init_done == !bus.stall);
  a_ack_in_done: assert property (@(posedge clk) disable iff (rst_i)
      bus.flush_ack |-> bus.init_done);
  a_cnt_tracks_rst: assert property (@(posedge clk) disable iff (rst_i)
      bus.bht_rst == (bus.busy_cnt != '0));
`endif

endmodule

// File: tb/tb_bht_init_seq.sv
// Self-checking bench for bht_init_seq: table of flush scenarios, hand-written corner
// sequences (merge, boundary, async reset, BHT training) and a randomized run, all checked
// cycle by cycle against a behavioural model, plus a BHT memory model fed by the init port.
module tb_bht_init_seq;
  localparam int unsigned N  = 256;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = AW + 1;
  // {bht_rst, bht_addr, bht_init, stall, init_done, flush_ack, busy_cnt}
  localparam logic [22:0] RstPack = {1'b1, 8'd0, 2'b01, 1'b1, 1'b0, 1'b0, 9'd256};

  logic          clk = 1'b0;
  logic          rst, req, pe;
  logic [1:0]    val;
  logic          upd_en;
  logic [AW-1:0] upd_addr;
  logic [1:0]    upd_val;
  logic [1:0]    mem [N];
  int            checks = 0;
  int            errors = 0;

  bht_init_seq_if #(.ADDR_W(AW)) bht_if ();
  assign bht_if.flush_req  = req;
  assign bht_if.flush_val  = val;
  assign bht_if.pipe_empty = pe;

  bht_init_seq #(.BHT_SIZE(N), .ADDR_W(AW), .INIT_STATE(2'b01)) dut (
    .clk  (clk),
    .rst_i(rst),
    .bus  (bht_if)
  );

  always #5 clk = ~clk;

  // BHT storage: init port has priority over MEM-stage updates.
  always @(posedge clk) begin
    if (bht_if.bht_rst) mem[bht_if.bht_addr] <= bht_if.bht_init;
    else if (upd_en) mem[upd_addr] <= upd_val;
  end

  // Behavioural model: entries left to write, drain flag, pending request.
  int         m_left;
  bit         m_drain, m_pend, m_flush, m_ack;
  logic [1:0] m_pval, m_val;

  task automatic model_reset();
    m_left = N; m_drain = 0; m_pend = 0; m_flush = 0; m_ack = 0;
    m_val = 2'b01; m_pval = 2'b00;
  endtask

  task automatic model_step(input logic r, input logic [1:0] v, input logic p);
    bit fin;
    fin = 0;
    if (m_left > 0) begin
      if (r) begin m_pend = 1; m_pval = v; end
      m_left--;
      if (m_left == 0) fin = m_flush;
    end else if (m_drain) begin
      if (r) begin m_pend = 1; m_pval = v; end
      if (p) begin m_drain = 0; m_left = N; end
    end else if (r || m_pend) begin
      m_val   = r ? v : m_pval;
      m_pend  = 0;
      m_drain = 1;
      m_flush = 1;
    end
    m_ack = fin;
  endtask

  function automatic logic [22:0] pack_dut();
    return {bht_if.bht_rst, bht_if.bht_addr, bht_if.bht_init, bht_if.stall,
            bht_if.init_done, bht_if.flush_ack, bht_if.busy_cnt};
  endfunction

  function automatic logic [22:0] pack_model();
    logic          busy, stl;
    logic [AW-1:0] a;
    busy = (m_left > 0);
    stl  = busy || m_drain;
    a    = AW'((N - m_left) % N);
    return {busy, a, m_val, stl, !stl, m_ack, CW'(m_left)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    if (upd_en) check("update_vs_init_collision", 32'(bht_if.bht_rst), 32'd0);
    if (rst) model_reset();
    else model_step(req, val, pe);
    @(negedge clk);
    check("outputs_vs_model", 32'(pack_dut()), 32'(pack_model()));
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    while (!bht_if.flush_ack && n < 700) begin tick(); n++; end
    check(name, 32'(bht_if.flush_ack), 32'd1);
  endtask

  task automatic check_mem(input string name, input logic [1:0] v);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== v) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic run_flush(input logic [1:0] v, input int drain, input logic [1:0] fill);
    req = 1'b1; val = v; pe = 1'b0;
    tick();
    req = 1'b0;
    for (int i = 0; i < drain; i++) begin
      check("drain_stall_no_write", 32'({bht_if.stall, bht_if.bht_rst}), 32'b10);
      tick();
    end
    pe = 1'b1;
    tick();
    pe = 1'b0;
    wait_ack("flush_ack_seen");
    check_mem("flush_fill", fill);
    tick();
    check("flush_ack_one_cycle", 32'(bht_if.flush_ack), 32'd0);
  endtask

  typedef struct {
    logic [1:0] val;
    int         drain;
    logic [1:0] fill;
  } flush_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    flush_vec_t tbl [3];
    int         hi, acks, n;
    tbl[0] = '{val: 2'b11, drain: 5, fill: 2'b11};
    tbl[1] = '{val: 2'b10, drain: 3, fill: 2'b10};
    tbl[2] = '{val: 2'b01, drain: 1, fill: 2'b01};

    rst = 1'b1; req = 1'b0; pe = 1'b0; val = 2'b00;
    upd_en = 1'b0; upd_addr = '0; upd_val = 2'b00;
    model_reset();

    // Power-on
    repeat (3) tick();
    check("reset_state", 32'(pack_dut()), 32'(RstPack));
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i < N; i++) begin
      if (bht_if.bht_rst) hi++;
      check("poweron_addr", 32'(bht_if.bht_addr), 32'(i));
      tick();
    end
    check("poweron_rst_len", 32'(hi), 32'(N));
    check("poweron_done", 32'({bht_if.bht_rst, bht_if.init_done, bht_if.stall,
                               bht_if.flush_ack}), 32'b0100);
    check_mem("poweron_fill", 2'b01);
    repeat (3) tick();
    check("poweron_no_ack", 32'(bht_if.flush_ack), 32'd0);

    // Table-driven flushes with a busy pipeline
    foreach (tbl[k]) run_flush(tbl[k].val, tbl[k].drain, tbl[k].fill);

    // Merged requests during a sweep
    pe = 1'b1; req = 1'b1; val = 2'b11;
    tick();
    req = 1'b0;
    tick();
    repeat (10) tick();
    req = 1'b1; val = 2'b00; tick(); req = 1'b0;
    repeat (20) tick();
    req = 1'b1; val = 2'b10; tick(); req = 1'b0;
    acks = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (bht_if.flush_ack) acks++;
    end
    check("merged_ack_count", 32'(acks), 32'd2);
    check_mem("merged_fill", 2'b10);
    check("merged_settled", 32'(bht_if.init_done), 32'd1);

    // Request on the edge that writes the last entry
    req = 1'b1; val = 2'b01; tick(); req = 1'b0;
    tick();
    n = 0;
    while (bht_if.busy_cnt != 9'd1 && n < 300) begin tick(); n++; end
    check("boundary_reached", 32'(bht_if.busy_cnt), 32'd1);
    req = 1'b1; val = 2'b11; tick(); req = 1'b0;
    check("boundary_done_cycle", 32'({bht_if.init_done, bht_if.flush_ack, bht_if.stall}),
          32'b110);
    tick();
    check("boundary_drain", 32'({bht_if.stall, bht_if.init_done, bht_if.bht_rst}), 32'b100);
    wait_ack("boundary_ack");
    check_mem("boundary_fill", 2'b11);

    // Async reset mid-sweep with a pending request
    req = 1'b1; val = 2'b10; tick(); req = 1'b0;
    tick();
    repeat (5) tick();
    req = 1'b1; val = 2'b00; tick(); req = 1'b0;
    n = 0;
    while (bht_if.bht_addr != 8'd100 && n < 300) begin tick(); n++; end
    check("async_reached_100", 32'(bht_if.bht_addr), 32'd100);
    #2 rst = 1'b1;
    #1 check("async_reset_immediate", 32'(pack_dut()), 32'(RstPack));
    tick();
    tick();
    rst = 1'b0;
    repeat (N) tick();
    check_mem("async_restart_fill", 2'b01);
    repeat (20) tick();
    check("async_pending_dropped", 32'({bht_if.init_done, bht_if.stall}), 32'b10);

    // BHT integration: train entry 5, then flush to 00
    upd_en = 1'b1; upd_addr = 8'd5; upd_val = 2'b11;
    tick();
    upd_en = 1'b0;
    check("train_entry5", 32'(mem[5]), 32'b11);
    run_flush(2'b00, 2, 2'b00);
    check("entry5_after_flush", 32'(mem[5]), 32'b00);
    check("entry5_tnt", 32'(mem[5][1]), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req      = ($urandom_range(0, 99) < 3);
      val      = 2'($urandom);
      pe       = 1'($urandom_range(0, 1));
      upd_en   = !bht_if.stall && ($urandom_range(0, 3) == 0);
      upd_addr = AW'($urandom);
      upd_val  = 2'($urandom);
      tick();
    end
    upd_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
